rename_ckpt_ctrl: RTL and testbench

//  Branch-checkpoint controller for the speculative free list in the rename stage.
//  - Snapshots the free-list head pointer for each renamed branch into a circular checkpoint buffer.
//  - Retires checkpoints in order as their branches resolve correctly.
//  - On a mispredict, sequences free-list recovery: drives freeListHeadCp/flagRecoverEX/ctrlVerified, then stalls rename.

---
 rtl/rename_pkg.sv | 36 +++
 rtl/ckpt_snap_ram.sv | 32 +++
 rtl/rename_ckpt_ctrl.sv | 176 +++++++++++++++++
 tb/tb_rename_ckpt_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rename_pkg
// Brief   : Shared types, sizes and helpers for the rename checkpoint logic.
// Rev     : 1.0
// ============================================================================
package rename_pkg;

  localparam int NUM_CKPT       = 8;
  localparam int CKPT_LOG       = 3;
  localparam int SIZE_FL        = 64;
  localparam int SIZE_FL_LOG    = 6;
  localparam int DISPATCH_WIDTH = 4;

  typedef logic [CKPT_LOG-1:0]    ckpt_id_t;
  typedef logic [CKPT_LOG:0]      ckpt_cnt_t;
  typedef logic [SIZE_FL_LOG-1:0] fl_ptr_t;
  typedef logic [2:0]             br_off_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECOVER = 2'd1,
    FLUSH   = 2'd2
  } ckpt_state_e;

  // Free-list head advanced by the pops ahead of the branch, wrapped once.
  function automatic fl_ptr_t flWrapAdd(input fl_ptr_t base, input br_off_t off);
    logic [SIZE_FL_LOG:0] sum;
    sum = {1'b0, base} + {{(SIZE_FL_LOG-2){1'b0}}, off};
    if (sum >= (SIZE_FL_LOG+1)'(SIZE_FL))
      sum = sum - (SIZE_FL_LOG+1)'(SIZE_FL);
    return sum[SIZE_FL_LOG-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ckpt_snap_ram.sv
`default_nettype none
// ============================================================================
// Module  : ckpt_snap_ram
// Brief   : Free-list head snapshot store, one write port and one async read.
// Rev     : 1.0
// ============================================================================
module ckpt_snap_ram
  import rename_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     wrEn,
  input  ckpt_id_t wrAddr,
  input  fl_ptr_t  wrData,
  input  ckpt_id_t rdAddr,
  output fl_ptr_t  rdData
);

  fl_ptr_t r_mem [NUM_CKPT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CKPT; i++) r_mem[i] <= '0;
    end else if (wrEn) begin
      r_mem[wrAddr] <= wrData;
    end
  end

  assign rdData = r_mem[rdAddr];

endmodule
`default_nettype wire

// File: rtl/rename_ckpt_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rename_ckpt_ctrl
// Brief   : Branch checkpoint controller for the speculative free list.
//           Optional counters enabled by RENAME_CKPT_PERF_EN.
// Rev     : 1.0
// ============================================================================
module rename_ckpt_ctrl
  import rename_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     recoverFlag_i,
  input  logic     stall_i,
  input  logic     renameValid_i,
  input  logic     brInBundle_i,
  input  br_off_t  brHeadOffset_i,
  input  fl_ptr_t  freeListHead_i,
  input  logic     resolveValid_i,
  input  ckpt_id_t resolveId_i,
  input  logic     mispredict_i,
  output ckpt_id_t ckptId_o,
  output logic     ckptFull_o,
  output logic     renameStall_o,
  output fl_ptr_t  freeListHeadCp_o,
  output logic     flagRecoverEX_o,
  output logic     ctrlVerified_o
`ifdef RENAME_CKPT_PERF_EN
  ,
  output logic [31:0] ckptAllocCnt_o,
  output logic [31:0] ckptMispredCnt_o,
  output logic [31:0] ckptFullStallCyc_o
`endif
);

  ckpt_state_e         r_state, w_nextState;
  ckpt_id_t            r_ckptHead, r_ckptTail, r_pendId;
  ckpt_cnt_t           r_ckptCnt, w_cntNext;
  logic [NUM_CKPT-1:0] r_valid, r_resolved, w_validNext, w_resolvedNext, w_squash;
  ckpt_id_t            w_entryAge [NUM_CKPT];
  ckpt_id_t            w_pendAge, w_resAge;
  fl_ptr_t             w_snapRd;
  logic                w_alloc, w_retire, w_resHit, w_correct, w_mispred;
  logic                w_older, w_takeMispred;

  assign ckptFull_o = (r_ckptCnt == ckpt_cnt_t'(NUM_CKPT));
  assign ckptId_o   = r_ckptTail;

  assign w_alloc   = (r_state == IDLE) & renameValid_i & brInBundle_i & ~stall_i & ~ckptFull_o;
  assign w_retire  = r_valid[r_ckptHead] & r_resolved[r_ckptHead];
  assign w_resHit  = resolveValid_i & r_valid[resolveId_i];
  assign w_correct = w_resHit & ~mispredict_i;
  assign w_mispred = w_resHit & mispredict_i;

  // Ages are distances from the oldest live entry; smaller means older.
  assign w_pendAge = r_pendId - r_ckptHead;
  assign w_resAge  = resolveId_i - r_ckptHead;
  assign w_older   = (w_resAge < w_pendAge);

  assign w_takeMispred = w_mispred & ((r_state == IDLE) | w_older);

  for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_squash
    assign w_entryAge[gi] = ckpt_id_t'(gi) - r_ckptHead;
    assign w_squash[gi]   = (w_entryAge[gi] > w_pendAge);
  end

  ckpt_snap_ram u_snapRam (
    .clk    (clk),
    .reset  (reset),
    .wrEn   (w_alloc),
    .wrAddr (r_ckptTail),
    .wrData (flWrapAdd(freeListHead_i, brHeadOffset_i)),
    .rdAddr (r_pendId),
    .rdData (w_snapRd)
  );

  always_comb begin
    w_nextState      = r_state;
    renameStall_o    = 1'b0;
    flagRecoverEX_o  = 1'b0;
    ctrlVerified_o   = 1'b0;
    freeListHeadCp_o = '0;
    unique case (r_state)
      IDLE: begin
        if (w_takeMispred) w_nextState = RECOVER;
      end
      RECOVER: begin
        renameStall_o    = 1'b1;
        flagRecoverEX_o  = 1'b1;
        ctrlVerified_o   = 1'b1;
        freeListHeadCp_o = w_snapRd;
        w_nextState      = w_takeMispred ? RECOVER : FLUSH;
      end
      FLUSH: begin
        renameStall_o = 1'b1;
        w_nextState   = w_takeMispred ? RECOVER : IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Squash is applied before retire so a retiring pendId stays cleared.
  always_comb begin
    w_validNext    = r_valid;
    w_resolvedNext = r_resolved;
    if (w_correct) w_resolvedNext[resolveId_i] = 1'b1;
    if (r_state == RECOVER) begin
      w_resolvedNext[r_pendId] = 1'b1;
      w_validNext              = w_validNext & ~w_squash;
      w_resolvedNext           = w_resolvedNext & ~w_squash;
    end
    if (w_retire) begin
      w_validNext[r_ckptHead]    = 1'b0;
      w_resolvedNext[r_ckptHead] = 1'b0;
    end
    if (w_alloc) begin
      w_validNext[r_ckptTail]    = 1'b1;
      w_resolvedNext[r_ckptTail] = 1'b0;
    end
  end

  always_comb begin
    w_cntNext = r_ckptCnt;
    if (r_state == RECOVER) begin
      w_cntNext = {1'b0, w_pendAge} + ckpt_cnt_t'(1);
      if (w_retire) w_cntNext = w_cntNext - ckpt_cnt_t'(1);
    end else if (w_alloc && !w_retire) begin
      w_cntNext = r_ckptCnt + ckpt_cnt_t'(1);
    end else if (!w_alloc && w_retire) begin
      w_cntNext = r_ckptCnt - ckpt_cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || recoverFlag_i) begin
      r_state    <= IDLE;
      r_ckptHead <= '0;
      r_ckptTail <= '0;
      r_ckptCnt  <= '0;
      r_valid    <= '0;
      r_resolved <= '0;
      r_pendId   <= '0;
    end else begin
      r_state    <= w_nextState;
      r_valid    <= w_validNext;
      r_resolved <= w_resolvedNext;
      r_ckptCnt  <= w_cntNext;
      if (w_takeMispred) r_pendId <= resolveId_i;
      if (w_retire) r_ckptHead <= r_ckptHead + ckpt_id_t'(1);
      if (r_state == RECOVER) r_ckptTail <= r_pendId + ckpt_id_t'(1);
      else if (w_alloc) r_ckptTail <= r_ckptTail + ckpt_id_t'(1);
    end
  end

`ifdef RENAME_CKPT_PERF_EN
  logic [31:0] r_allocCnt, r_mispredCnt, r_fullStallCyc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_allocCnt     <= '0;
      r_mispredCnt   <= '0;
      r_fullStallCyc <= '0;
    end else begin
      r_allocCnt     <= r_allocCnt + 32'(w_alloc);
      r_mispredCnt   <= r_mispredCnt + 32'(w_takeMispred);
      r_fullStallCyc <= r_fullStallCyc + 32'(ckptFull_o & renameValid_i & brInBundle_i);
    end
  end

  assign ckptAllocCnt_o     = r_allocCnt;
  assign ckptMispredCnt_o   = r_mispredCnt;
  assign ckptFullStallCyc_o = r_fullStallCyc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rename_ckpt_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_rename_ckpt_ctrl
// Brief   : Directed bench for rename_ckpt_ctrl with a queue-based reference.
// Rev     : 1.0
// ============================================================================
module tb_rename_ckpt_ctrl;
  import rename_pkg::*;

  logic     clk = 1'b0;
  logic     reset, recoverFlag_i, stall_i, renameValid_i, brInBundle_i;
  br_off_t  brHeadOffset_i;
  fl_ptr_t  freeListHead_i;
  logic     resolveValid_i, mispredict_i;
  ckpt_id_t resolveId_i;
  ckpt_id_t ckptId_o;
  logic     ckptFull_o, renameStall_o, flagRecoverEX_o, ctrlVerified_o;
  fl_ptr_t  freeListHeadCp_o;
`ifdef RENAME_CKPT_PERF_EN
  logic [31:0] ckptAllocCnt_o, ckptMispredCnt_o, ckptFullStallCyc_o;
`endif

  always #5 clk = ~clk;

  rename_ckpt_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .recoverFlag_i    (recoverFlag_i),
    .stall_i          (stall_i),
    .renameValid_i    (renameValid_i),
    .brInBundle_i     (brInBundle_i),
    .brHeadOffset_i   (brHeadOffset_i),
    .freeListHead_i   (freeListHead_i),
    .resolveValid_i   (resolveValid_i),
    .resolveId_i      (resolveId_i),
    .mispredict_i     (mispredict_i),
    .ckptId_o         (ckptId_o),
    .ckptFull_o       (ckptFull_o),
    .renameStall_o    (renameStall_o),
    .freeListHeadCp_o (freeListHeadCp_o),
    .flagRecoverEX_o  (flagRecoverEX_o),
    .ctrlVerified_o   (ctrlVerified_o)
`ifdef RENAME_CKPT_PERF_EN
    ,
    .ckptAllocCnt_o     (ckptAllocCnt_o),
    .ckptMispredCnt_o   (ckptMispredCnt_o),
    .ckptFullStallCyc_o (ckptFullStallCyc_o)
`endif
  );

  int checks   = 0;
  int failures = 0;
  bit modelOn  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: live checkpoints kept oldest-first; mode 0 idle, 1 recover, 2 flush.
  typedef struct { int id; int snap; bit res; } ent_t;
  ent_t q[$];
  int   mHead = 0;
  int   mMode = 0;
  int   mPend = 0;

  function automatic int findIdx(input int id);
    foreach (q[k]) if (q[k].id == id) return k;
    return -1;
  endfunction

  function automatic int age(input int id);
    return (id - mHead + 8) % 8;
  endfunction

  task automatic modelStep();
    int k, nextMode, oldPend, p, tailId, sz;
    bit ret, alc;
    if (reset || recoverFlag_i) begin
      q.delete(); mHead = 0; mMode = 0; mPend = 0;
      return;
    end
    sz      = q.size();
    tailId  = (mHead + sz) % 8;
    ret     = (sz > 0) && q[0].res;
    alc     = (mMode == 0) && renameValid_i && brInBundle_i && !stall_i && (sz < 8);
    k       = resolveValid_i ? findIdx(int'(resolveId_i)) : -1;
    oldPend = mPend;
    nextMode = (mMode == 1) ? 2 : 0;
    if (k >= 0) begin
      if (!mispredict_i) q[k].res = 1'b1;
      else if (mMode == 0 || age(int'(resolveId_i)) < age(oldPend)) begin
        mPend = int'(resolveId_i);
        nextMode = 1;
      end
    end
    if (mMode == 1) begin
      p = findIdx(oldPend);
      if (p >= 0) begin
        while (q.size() > p + 1) void'(q.pop_back());
        q[p].res = 1'b1;
      end
    end
    if (ret) begin
      void'(q.pop_front());
      mHead = (mHead + 1) % 8;
    end
    if (alc)
      q.push_back('{id: tailId, snap: (int'(freeListHead_i) + int'(brHeadOffset_i)) % 64, res: 1'b0});
    mMode = nextMode;
  endtask

  always @(posedge clk) modelStep();

  always @(negedge clk) begin
    int p, eCp;
    if (modelOn) begin
      p   = findIdx(mPend);
      eCp = (mMode == 1 && p >= 0) ? q[p].snap : 0;
      chk("m_ckptId",   int'(ckptId_o),         (mHead + q.size()) % 8);
      chk("m_full",     int'(ckptFull_o),       int'(q.size() == 8));
      chk("m_stall",    int'(renameStall_o),    int'(mMode != 0));
      chk("m_recover",  int'(flagRecoverEX_o),  int'(mMode == 1));
      chk("m_verified", int'(ctrlVerified_o),   int'(mMode == 1));
      chk("m_headCp",   int'(freeListHeadCp_o), eCp);
      chk("m_cnt",      int'(dut.r_ckptCnt),    q.size());
    end
  end

  task automatic idleIn();
    recoverFlag_i = 0; stall_i = 0; renameValid_i = 0; brInBundle_i = 0;
    brHeadOffset_i = '0; freeListHead_i = '0;
    resolveValid_i = 0; resolveId_i = '0; mispredict_i = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    idleIn(); reset = 1; step(); reset = 0;
  endtask

  task automatic alloc(input int fh, input int off);
    renameValid_i = 1; brInBundle_i = 1;
    freeListHead_i = fl_ptr_t'(fh); brHeadOffset_i = br_off_t'(off);
    step(); idleIn();
  endtask

  task automatic setResolve(input int id, input bit mis);
    resolveValid_i = 1; resolveId_i = ckpt_id_t'(id); mispredict_i = mis;
  endtask

  task automatic resolve(input int id, input bit mis);
    setResolve(id, mis); step(); idleIn();
  endtask

  initial begin
    idleIn();
    reset = 1;
    step(); step();
    reset = 0;
    modelOn = 1;

    // 1: reset state, then wrap-around snapshot 62+3 -> 1
    @(negedge clk);
    chk("rst_ckptId", int'(ckptId_o), 0);
    chk("rst_full",   int'(ckptFull_o), 0);
    chk("rst_stall",  int'(renameStall_o), 0);
    chk("rst_cp",     int'(freeListHeadCp_o), 0);
    alloc(62, 3);
    @(negedge clk);
    chk("t1_ckptId", int'(ckptId_o), 1);
    chk("t1_cnt",    int'(dut.r_ckptCnt), 1);
    resolve(0, 1);
    @(negedge clk);
    chk("t1_wrapSnap", int'(freeListHeadCp_o), 1);
    step(); step();

    // 2: fill, blocked allocation, retire unblocks one cycle later
    doReset();
    for (int i = 0; i < 8; i++) alloc(i * 8, 0);
    @(negedge clk);
    chk("t2_full", int'(ckptFull_o), 1);
    renameValid_i = 1; brInBundle_i = 1; freeListHead_i = 6'd50;
    step(); idleIn();
    @(negedge clk);
    chk("t2_blockedId", int'(ckptId_o), 0);
    resolve(0, 0);
    @(negedge clk);
    chk("t2_fullStill", int'(ckptFull_o), 1);
    step();
    @(negedge clk);
    chk("t2_fullClear", int'(ckptFull_o), 0);
    alloc(5, 0);
    @(negedge clk);
    chk("t2_refull", int'(ckptFull_o), 1);

    // 3: mispredict id2 among snaps 10..26
    doReset();
    for (int i = 0; i < 5; i++) alloc(10 + 4 * i, 0);
    resolve(2, 1);
    @(negedge clk);
    chk("t3_flag", int'(flagRecoverEX_o), 1);
    chk("t3_verif", int'(ctrlVerified_o), 1);
    chk("t3_cp", int'(freeListHeadCp_o), 18);
    chk("t3_stallR", int'(renameStall_o), 1);
    step();
    @(negedge clk);
    chk("t3_stallF", int'(renameStall_o), 1);
    chk("t3_flagF", int'(flagRecoverEX_o), 0);
    chk("t3_tail", int'(ckptId_o), 3);
    chk("t3_cnt", int'(dut.r_ckptCnt), 3);
    step();
    @(negedge clk);
    chk("t3_idle", int'(renameStall_o), 0);
    stall_i = 1; renameValid_i = 1; brInBundle_i = 1;
    step(); idleIn();
    @(negedge clk);
    chk("t3_stallNoAlloc", int'(ckptId_o), 3);
    renameValid_i = 1; brInBundle_i = 1; freeListHead_i = 6'd40;
    setResolve(0, 1);
    step(); idleIn();
    @(negedge clk);
    chk("t3_allocWithMis", int'(ckptId_o), 4);
    chk("t3_cp0", int'(freeListHeadCp_o), 10);
    step();
    @(negedge clk);
    chk("t3_tailAfterSquash", int'(ckptId_o), 1);
    step();

    // 4: older mispredict during RECOVER replaces the pending one
    doReset();
    for (int i = 0; i < 5; i++) alloc(10 + 4 * i, 0);
    setResolve(3, 1);
    step();
    setResolve(1, 1);
    step(); idleIn();
    @(negedge clk);
    chk("t4_flag2", int'(flagRecoverEX_o), 1);
    chk("t4_cp1", int'(freeListHeadCp_o), 14);
    setResolve(4, 1);
    step(); idleIn();
    @(negedge clk);
    chk("t4_flush", int'(renameStall_o), 1);
    chk("t4_noRe", int'(flagRecoverEX_o), 0);
    chk("t4_tail", int'(ckptId_o), 2);
    step();
    @(negedge clk);
    chk("t4_idle", int'(renameStall_o), 0);

    // 5: out-of-order resolves retire in order
    doReset();
    for (int i = 0; i < 4; i++) alloc(i, 1);
    resolve(2, 0);
    resolve(1, 0);
    resolve(0, 0);
    @(negedge clk);
    chk("t5_cnt4", int'(dut.r_ckptCnt), 4);
    step();
    @(negedge clk);
    chk("t5_cnt3", int'(dut.r_ckptCnt), 3);
    step();
    @(negedge clk);
    chk("t5_cnt2", int'(dut.r_ckptCnt), 2);
    step();
    @(negedge clk);
    chk("t5_cnt1", int'(dut.r_ckptCnt), 1);
    chk("t5_head", int'(dut.r_ckptHead), 3);
    step();
    @(negedge clk);
    chk("t5_noExtraRetire", int'(dut.r_ckptHead), 3);

    // 6: full flush mid-RECOVER, via recoverFlag_i and then with reset too
    for (int r = 0; r < 2; r++) begin
      doReset();
      for (int i = 0; i < 3; i++) alloc(20 + i, 0);
      resolve(1, 1);
      recoverFlag_i = 1;
      if (r == 1) reset = 1;
      step();
      reset = 0; idleIn();
      @(negedge clk);
      chk("t6_cnt", int'(dut.r_ckptCnt), 0);
      chk("t6_state", int'(dut.r_state), int'(IDLE));
      chk("t6_flag", int'(flagRecoverEX_o), 0);
      chk("t6_stall", int'(renameStall_o), 0);
      chk("t6_cp", int'(freeListHeadCp_o), 0);
      chk("t6_id", int'(ckptId_o), 0);
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
